// File: rtl/clk_en_divider_bank.sv
// ============================================================================
// Module   : clk_en_divider_bank
// Brief    : Multi-channel clock-enable divider bank with runtime-reloadable
//            divisors, common sync realignment and a lock indicator.
//            Optional macro CLK_EN_DIVIDER_BANK_PHASE_OFFSET_EN adds ph_in
//            for per-channel start-phase offsets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_en_divider_bank #(
    parameter int NCH         = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10,
    parameter int LOCK_TICKS  = 4
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic [NCH*DIV_W-1:0] div_in,
    input  logic [NCH-1:0]       div_load,
    input  logic                 sync,
`ifdef CLK_EN_DIVIDER_BANK_PHASE_OFFSET_EN
    input  logic [NCH*DIV_W-1:0] ph_in,
`endif
    output logic [NCH-1:0]       en_out,
    output logic [NCH-1:0]       clk_out,
    output logic                 lock
);

    localparam logic [DIV_W-1:0] C_DEF_DIV    = DIV_W'(DEFAULT_DIV);
    localparam logic [7:0]       C_LAST_TICK  = 8'(LOCK_TICKS - 1);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    logic           r_run;
    logic           w_restart;
    logic [NCH-1:0] w_wrap_vec;

    // r_run is low only for the first edge after reset, which acts as a start
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_restart = ~r_run | sync;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_pend;
        logic             r_pend_v;
        logic             r_en;
        logic             r_clk;

        logic [DIV_W-1:0] w_slice;
        logic [DIV_W-1:0] w_n;
        logic             w_wrap;
        logic             w_apply;
        logic [DIV_W-1:0] w_div_nxt;
        logic [DIV_W-1:0] w_n_nxt;
        logic [DIV_W-1:0] w_start;
        logic [DIV_W-1:0] w_cnt_nxt;
        logic [DIV_W-1:0] w_half_nxt;

        always_comb begin
            w_slice = div_in[i*DIV_W +: DIV_W];
            w_n     = (r_div == '0) ? DIV_W'(1) : r_div;
            w_wrap  = r_run && (r_cnt == w_n - 1'b1);
            w_apply = w_restart | w_wrap;

            // A load in the same cycle as the apply point wins over the pending value
            w_div_nxt = r_div;
            if (w_apply) begin
                if (div_load[i]) begin
                    w_div_nxt = w_slice;
                end else if (r_pend_v) begin
                    w_div_nxt = r_pend;
                end
            end
            w_n_nxt = (w_div_nxt == '0) ? DIV_W'(1) : w_div_nxt;

`ifdef CLK_EN_DIVIDER_BANK_PHASE_OFFSET_EN
            w_start = ph_in[i*DIV_W +: DIV_W] % w_n_nxt;
`else
            w_start = '0;
`endif

            w_cnt_nxt = r_cnt + 1'b1;
            if (w_restart) begin
                w_cnt_nxt = w_start;
            end else if (w_wrap) begin
                w_cnt_nxt = '0;
            end

            w_half_nxt = (w_n_nxt >> 1) + {{(DIV_W-1){1'b0}}, w_n_nxt[0]};
        end

        always_ff @(posedge clkin) begin
            if (reset) begin
                r_cnt    <= '0;
                r_div    <= C_DEF_DIV;
                r_pend   <= C_DEF_DIV;
                r_pend_v <= 1'b0;
                r_en     <= 1'b0;
                r_clk    <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_div <= w_div_nxt;
                if (div_load[i]) begin
                    r_pend <= w_slice;
                end
                if (w_apply) begin
                    r_pend_v <= 1'b0;
                end else if (div_load[i]) begin
                    r_pend_v <= 1'b1;
                end
                r_en  <= ~sync && (w_cnt_nxt == w_n_nxt - 1'b1);
                r_clk <= (w_cnt_nxt < w_half_nxt);
            end
        end

        assign en_out[i]     = r_en;
        assign clk_out[i]    = r_clk;
        assign w_wrap_vec[i] = w_wrap;
    end

    lock_state_t r_state;
    logic [7:0]  r_ticks;
    logic        r_lock;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state <= ST_SETTLE;
            r_ticks <= '0;
            r_lock  <= 1'b0;
        end else if (sync || (|div_load)) begin
            r_state <= ST_SETTLE;
            r_ticks <= '0;
            r_lock  <= 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    r_lock <= 1'b0;
                    if (w_wrap_vec[0]) begin
                        if (r_ticks == C_LAST_TICK) begin
                            r_state <= ST_LOCKED;
                            r_lock  <= 1'b1;
                        end else begin
                            r_ticks <= r_ticks + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    r_lock <= 1'b1;
                end
                default: begin
                    r_state <= ST_SETTLE;
                    r_ticks <= '0;
                    r_lock  <= 1'b0;
                end
            endcase
        end
    end

    assign lock = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_clk_en_divider_bank.sv
// ============================================================================
// Module   : tb_clk_en_divider_bank
// Brief    : Directed plus randomized bench with a period-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_en_divider_bank;

    localparam int NCH   = 2;
    localparam int DIV_W = 8;
    localparam int DEF   = 10;
    localparam int LT    = 4;

    logic                 clkin = 1'b0;
    logic                 reset;
    logic [NCH*DIV_W-1:0] div_in;
    logic [NCH-1:0]       div_load;
    logic                 sync;
    logic [NCH-1:0]       en_out;
    logic [NCH-1:0]       clk_out;
    logic                 lock;
`ifdef CLK_EN_DIVIDER_BANK_PHASE_OFFSET_EN
    logic [NCH*DIV_W-1:0] ph_in = '0;
`endif

    always #5 clkin = ~clkin;

    clk_en_divider_bank #(
        .NCH(NCH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF), .LOCK_TICKS(LT)
    ) dut (
        .clkin   (clkin),
        .reset   (reset),
        .div_in  (div_in),
        .div_load(div_load),
        .sync    (sync),
`ifdef CLK_EN_DIVIDER_BANK_PHASE_OFFSET_EN
        .ph_in   (ph_in),
`endif
        .en_out  (en_out),
        .clk_out (clk_out),
        .lock    (lock)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position within the current period, active period length,
    // pending period, and the number of channel-0 periods completed since settling.
    int             m_pos  [NCH];
    int             m_per  [NCH];
    int             m_pend [NCH];
    bit             m_pv   [NCH];
    bit             m_run;
    bit             m_lock;
    int             m_ticks;
    logic [NCH-1:0] m_en;
    logic [NCH-1:0] m_clk;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_edge();
        bit restart;
        bit wrap0;
        bit last;
        int sl;
        int nd;
        int n;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_pos[c] = 0; m_per[c] = DEF; m_pend[c] = DEF; m_pv[c] = 0;
            end
            m_run = 0; m_lock = 0; m_ticks = 0; m_en = '0; m_clk = '0;
        end else begin
            restart = !m_run || sync;
            wrap0   = m_run && (m_pos[0] == eff(m_per[0]) - 1);
            for (int c = 0; c < NCH; c++) begin
                last = m_run && (m_pos[c] == eff(m_per[c]) - 1);
                sl   = int'(div_in[c*DIV_W +: DIV_W]);
                nd   = div_load[c] ? sl : (m_pv[c] ? m_pend[c] : m_per[c]);
                if (div_load[c]) m_pend[c] = sl;
                if (restart || last) begin
                    m_per[c] = nd;
                    m_pv[c]  = 0;
                    m_pos[c] = 0;
                end else begin
                    if (div_load[c]) m_pv[c] = 1;
                    m_pos[c] = m_pos[c] + 1;
                end
                n = eff(m_per[c]);
                m_en[c]  = !sync && (m_pos[c] == n - 1);
                m_clk[c] = (m_pos[c] < (n + 1) / 2);
            end
            if (sync || (|div_load)) begin
                m_lock = 0; m_ticks = 0;
            end else if (!m_lock && wrap0) begin
                m_ticks++;
                if (m_ticks == LT) m_lock = 1;
            end
            m_run = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        model_edge();
        @(negedge clkin);
        check("outputs", 32'({lock, clk_out, en_out}), 32'({m_lock, m_clk, m_en}));
    endtask

    task automatic clr();
        div_load = '0;
        sync     = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic load(input int c, input int v);
        div_in[c*DIV_W +: DIV_W] = DIV_W'(v);
        div_load[c] = 1'b1;
    endtask

    // Leaves the bench in cycle 0 after reset release.
    task automatic start_run();
        clr();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        div_in = '0;
        clr();

        // Defaults after release
        start_run();
        for (int t = 0; t <= 41; t++) begin
            if (t == 0)  check("s1_clk0_c0", 32'(clk_out[0]), 32'd1);
            if (t == 0)  check("s1_en0_c0", 32'(en_out[0]), 32'd0);
            if (t == 4)  check("s1_clk0_c4", 32'(clk_out[0]), 32'd1);
            if (t == 5)  check("s1_clk0_c5", 32'(clk_out[0]), 32'd0);
            if (t == 8)  check("s1_en0_c8", 32'(en_out[0]), 32'd0);
            if (t == 9 || t == 19 || t == 29) check("s1_en0_pulse", 32'(en_out[0]), 32'd1);
            if (t == 39) check("s1_lock_c39", 32'(lock), 32'd0);
            if (t == 40) check("s1_lock_c40", 32'(lock), 32'd1);
            clr();
            cyc();
        end

        // Reload channel 1 mid-period
        start_run();
        for (int t = 0; t <= 30; t++) begin
            if (t == 4)  check("s2_lock_c4", 32'(lock), 32'd0);
            if (t == 9 || t == 14 || t == 19 || t == 24) check("s2_en1_pulse", 32'(en_out[1]), 32'd1);
            if (t == 10 || t == 13) check("s2_en1_quiet", 32'(en_out[1]), 32'd0);
            clr();
            if (t == 3) load(1, 5);
            cyc();
        end

        // Sync realignment
        start_run();
        for (int t = 0; t <= 34; t++) begin
            if (t == 24) check("s3_en_c24", 32'(en_out), 32'd0);
            if (t == 27 || t == 31) check("s3_en1_pulse", 32'(en_out[1]), 32'd1);
            if (t == 32) check("s3_en0_c32", 32'(en_out[0]), 32'd0);
            if (t == 33) check("s3_en0_c33", 32'(en_out[0]), 32'd1);
            clr();
            if (t == 2)  load(1, 4);
            if (t == 23) sync = 1'b1;
            cyc();
        end

        // N=3, then N=0, then N=1 on channel 0
        start_run();
        for (int t = 0; t <= 24; t++) begin
            if (t == 10 || t == 11) check("s4_clk_hi", 32'(clk_out[0]), 32'd1);
            if (t == 12) check("s4_clk_lo", 32'(clk_out[0]), 32'd0);
            if (t == 12 || t == 15) check("s4_en_n3", 32'(en_out[0]), 32'd1);
            if (t >= 16) check("s4_n0_en_clk", 32'({clk_out[0], en_out[0]}), 32'd3);
            clr();
            if (t == 2)  load(0, 3);
            if (t == 13) load(0, 0);
            if (t == 20) load(0, 1);
            cyc();
        end

        // Reset mid-period discards a pending load
        start_run();
        for (int t = 0; t <= 17; t++) begin
            if (t == 6)  check("s5_rst_outs", 32'({lock, clk_out, en_out}), 32'd0);
            if (t == 10) check("s5_no_n4", 32'(en_out[0]), 32'd0);
            if (t == 16) check("s5_n10", 32'(en_out[0]), 32'd1);
            clr();
            if (t == 3) load(0, 4);
            if (t == 5) reset = 1'b1;
            cyc();
        end

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            clr();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 19) == 0) load(c, int'($urandom_range(0, 12)));
            end
            if ($urandom_range(0, 59) == 0)  sync  = 1'b1;
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
